id_operand_scoreboard: RTL and testbench
========================================

Name: id_operand_scoreboard

Overview:
- Parametrised decode-stage operand unit. It selects the rs/rt operands for the instruction in ID.
- Forwarding comes from N_FWD younger pipeline stages plus a long-latency writeback bypass.
- A per-register scoreboard tracks outstanding long-latency writes (load miss, div). The block raises stallreq on load-use, RAW-on-pending and WAW hazards, and runs a stall watchdog.
- Sits between the decoder and ID/EX. Feeds the control module's stall input.

Parameters:
DATA_W, 32, operand/data width
REG_AW, 5, register address width; 2**REG_AW architectural registers
N_FWD, 2, forwarding sources; index 0 is youngest (EX), highest priority
MAX_LONG, 4, max outstanding long-latency writes
TIMEOUT, 255, consecutive-stall cycles before stall_timeout asserts

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
id_valid  in  1  instruction present in ID
flush  in  1  kill ID instruction this cycle
rs_read, rt_read  in  1 each  source read enables
rs_addr, rt_addr  in  REG_AW each  source register addresses
imm  in  DATA_W  immediate used when a source read is disabled
issue_wreg  in  1  instruction writes a register
issue_wd  in  REG_AW  destination register
issue_long  in  1  destination result returns via long-latency writeback
reg1_data_i, reg2_data_i  in  DATA_W  regfile read data
fwd_wreg  in  N_FWD  per-source write enable
fwd_wd  in  N_FWD*REG_AW  per-source destination, packed, source 0 in LSBs
fwd_wdata  in  N_FWD*DATA_W  per-source data, packed
fwd_not_ready  in  N_FWD  source holds a load whose data is not yet available
wb_long_valid  in  1  long-latency result returning
wb_long_addr  in  REG_AW  its destination
wb_long_data  in  DATA_W  its data
reg1_o, reg2_o  out  DATA_W  selected operands
stallreq  out  1  stall request to control
long_outstanding  out  clog2(MAX_LONG+1)  pending long writes
stall_timeout  out  1  watchdog flag, sticky until reset

Behaviour:
- Operand select per source, combinational, first match wins:
  - read disabled -> imm
  - addr==0 -> 0; r0 is never forwarded or scoreboarded
  - lowest-index fwd source with fwd_wreg & fwd_wd==addr -> its fwd_wdata; raises load_use if its fwd_not_ready
  - wb_long_valid & wb_long_addr==addr -> wb_long_data
  - else regfile data
- Scoreboard:
  - pending[2**REG_AW] register.
  - raw_hazard: a read-enabled nonzero source has pending set and is not bypassed by wb_long this cycle.
  - waw_hazard: issue_wreg & issue_wd!=0 & pending[issue_wd] & not cleared by wb_long this cycle.
  - cap_hazard: issue_long & long_outstanding==MAX_LONG & no wb_long_valid this cycle.
- stallreq = id_valid & !flush & (load_use | raw_hazard | waw_hazard | cap_hazard). Combinational, same cycle.
- Issue condition: id_valid & !flush & !stallreq.
- Scoreboard update on the rising edge:
  - Clear pending[wb_long_addr] when wb_long_valid.
  - Set pending[issue_wd] when issue & issue_long & issue_wreg & issue_wd!=0.
  - Same address set and cleared in one cycle -> set wins.
  - wb_long_valid to a non-pending address is ignored; the counter does not decrement.
- long_outstanding: registered count of set bits. Net +1 on set, -1 on effective clear, unchanged on both. Never exceeds MAX_LONG, never below 0.
- Watchdog:
  - stall_cnt increments each cycle stallreq=1, saturating at TIMEOUT; zeroed on any non-stall cycle.
  - stall_timeout sets when stall_cnt reaches TIMEOUT and stays set until rst.
- flush:
  - Suppresses stallreq and issue.
  - Does not clear pending; in-flight long ops still write back.
- Reset (rst==0 at edge): pending, long_outstanding, stall_cnt and stall_timeout all go to 0.
  - While rst==0, reg1_o, reg2_o and stallreq are forced to 0.
  - Reset mid-operation discards all pending state; a later wb_long_valid for it is ignored.

Decomposition:
- Shared defines file: ZeroWord, NoStop/Stop, NOPRegAddr, and the packed-bus slicing widths.
- One sub-module, id_operand_mux, instantiated twice (rs, rt). It contains the priority forward/bypass select and emits the per-source load_use/raw flags.
- Scoreboard, counter and watchdog live in the top.

Test Plan:
- Forward priority:
  - Stimulus: fwd0 and fwd1 both write r5 (fwd0=0x11, fwd1=0x22); rs_addr=5.
  - Required: reg1_o=0x11, stallreq=0. With fwd_wreg[0]=0, reg1_o=0x22.
- Load-use:
  - Stimulus: fwd_not_ready[0]=1, fwd_wd[0]=7; rt_addr=7, rt_read=1.
  - Required: stallreq=1 that cycle, and 0 the next cycle once not_ready drops with fwd_wdata=0xABCD; reg2_o=0xABCD.
- Long RAW/bypass:
  - Stimulus: issue div to r9 (issue_long); next instruction reads r9.
  - Required: stallreq=1, long_outstanding=1. On the wb_long_valid cycle for r9 with data 0x5, reg1_o=0x5 and stallreq=0; the next cycle long_outstanding=0.
- Capacity and set-wins:
  - Stimulus: issue 4 long ops to r1..r4.
  - Required: a 5th long issue stalls. Issue to r3 in the same cycle wb clears r3 -> pending[3] stays 1, count stays 4.
- r0 and flush:
  - Stimulus: pending on r0 is attempted; then flush=1 with a raw hazard present.
  - Required: r0 reads give 0 with no stall. Under flush, stallreq=0 and pending is unchanged.
- Watchdog and reset:
  - Stimulus: hold the raw hazard for 255 cycles.
  - Required: stall_timeout=1 at cycle 255 and stays set. rst=0 for one edge -> all outputs 0, long_outstanding=0.

Source files
------------

// File: rtl/id_operand_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// id_operand_scoreboard_pkg
//   Shared constants and types for the decode-stage operand/scoreboard unit.
//   - ZERO_WORD / NOP_REG_ADDR : canonical zero operand and r0 address
//   - STOP / NO_STOP           : stall request encodings
//   - op_src_e                 : which path an operand was taken from
//   - slice_lsb()              : LSB position of entry idx in a packed bus
// ---------------------------------------------------------------------------
package id_operand_scoreboard_pkg;

    localparam int          MAX_DATA_W   = 64;
    localparam int          MAX_REG_AW   = 8;

    localparam logic [MAX_DATA_W-1:0] ZERO_WORD    = '0;
    localparam logic [MAX_REG_AW-1:0] NOP_REG_ADDR = '0;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [2:0] {
        SRC_IMM  = 3'd0,
        SRC_ZERO = 3'd1,
        SRC_FWD  = 3'd2,
        SRC_WB   = 3'd3,
        SRC_RF   = 3'd4
    } op_src_e;

    // LSB index of element idx in a bus of elements each w bits wide.
    function automatic int slice_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/id_operand_mux.sv
// ---------------------------------------------------------------------------
// id_operand_mux
//   Priority operand select for one source port of the ID stage.
//   Order: read disabled -> imm, r0 -> zero, lowest-index forwarding source,
//   long-latency writeback bypass, regfile.
//   Ports:
//     rd_en, addr          source read enable / register address
//     imm, rf_data         immediate and regfile read data
//     fwd_*                packed forwarding buses (source 0 in LSBs)
//     wb_long_*            long-latency writeback bypass
//     pending_bit          scoreboard bit of addr
//     operand              selected operand
//     load_use             selected forwarding source has no data yet
//     raw                  source waits on an outstanding long write
// ---------------------------------------------------------------------------
module id_operand_mux
    import id_operand_scoreboard_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int N_FWD  = 2
) (
    input  logic                      rd_en,
    input  logic [REG_AW-1:0]         addr,
    input  logic [DATA_W-1:0]         imm,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [N_FWD-1:0]          fwd_wreg,
    input  logic [N_FWD*REG_AW-1:0]   fwd_wd,
    input  logic [N_FWD*DATA_W-1:0]   fwd_wdata,
    input  logic [N_FWD-1:0]          fwd_not_ready,
    input  logic                      wb_long_valid,
    input  logic [REG_AW-1:0]         wb_long_addr,
    input  logic [DATA_W-1:0]         wb_long_data,
    input  logic                      pending_bit,
    output logic [DATA_W-1:0]         operand,
    output logic                      load_use,
    output logic                      raw
);

    logic [N_FWD-1:0]   fwd_hit;
    logic               fwd_any;
    logic [DATA_W-1:0]  fwd_data;
    logic               fwd_nr;
    logic               wb_hit;
    logic               addr_zero;
    op_src_e            src;

    generate
        for (genvar gi = 0; gi < N_FWD; gi++) begin : g_hit
            assign fwd_hit[gi] = fwd_wreg[gi] &&
                                 (fwd_wd[slice_lsb(gi, REG_AW) +: REG_AW] == addr);
        end
    endgenerate

    assign wb_hit    = wb_long_valid && (wb_long_addr == addr);
    assign addr_zero = (addr == NOP_REG_ADDR[REG_AW-1:0]);

    // Walk from the oldest source down so the youngest (index 0) hit
    // overwrites everything else.
    always_comb begin
        fwd_any  = 1'b0;
        fwd_data = ZERO_WORD[DATA_W-1:0];
        fwd_nr   = 1'b0;
        for (int i = N_FWD - 1; i >= 0; i--) begin
            if (fwd_hit[i]) begin
                fwd_any  = 1'b1;
                fwd_data = fwd_wdata[i*DATA_W +: DATA_W];
                fwd_nr   = fwd_not_ready[i];
            end
        end
    end

    always_comb begin
        src = SRC_RF;
        if (!rd_en)
            src = SRC_IMM;
        else if (addr_zero)
            src = SRC_ZERO;
        else if (fwd_any)
            src = SRC_FWD;
        else if (wb_hit)
            src = SRC_WB;
    end

    always_comb begin
        operand = rf_data;
        case (src)
            SRC_IMM:  operand = imm;
            SRC_ZERO: operand = ZERO_WORD[DATA_W-1:0];
            SRC_FWD:  operand = fwd_data;
            SRC_WB:   operand = wb_long_data;
            default:  operand = rf_data;
        endcase
    end

    assign load_use = (src == SRC_FWD) && fwd_nr;
    // A pending register is fine to read on the cycle its result returns.
    assign raw      = rd_en && !addr_zero && pending_bit && !wb_hit;

endmodule

// File: rtl/id_operand_scoreboard.sv
// ---------------------------------------------------------------------------
// id_operand_scoreboard
//   Decode-stage operand unit: rs/rt operand select with forwarding and
//   long-latency bypass, per-register scoreboard of outstanding long writes,
//   hazard stall request and a sticky stall watchdog.
//   Ports:
//     clk, rst                     clock, synchronous active-low reset
//     id_valid, flush              instruction present / kill it
//     rs_*, rt_*, imm              source reads and immediate
//     issue_wreg/wd/long           destination of the ID instruction
//     reg1_data_i, reg2_data_i     regfile read data
//     fwd_*                        packed forwarding buses, source 0 youngest
//     wb_long_*                    long-latency writeback
//     reg1_o, reg2_o               selected operands
//     stallreq                     stall request to control
//     long_outstanding             number of pending long writes
//     stall_timeout                sticky watchdog flag
// ---------------------------------------------------------------------------
module id_operand_scoreboard
    import id_operand_scoreboard_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int N_FWD    = 2,
    parameter int MAX_LONG = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           id_valid,
    input  logic                           flush,
    input  logic                           rs_read,
    input  logic                           rt_read,
    input  logic [REG_AW-1:0]              rs_addr,
    input  logic [REG_AW-1:0]              rt_addr,
    input  logic [DATA_W-1:0]              imm,
    input  logic                           issue_wreg,
    input  logic [REG_AW-1:0]              issue_wd,
    input  logic                           issue_long,
    input  logic [DATA_W-1:0]              reg1_data_i,
    input  logic [DATA_W-1:0]              reg2_data_i,
    input  logic [N_FWD-1:0]               fwd_wreg,
    input  logic [N_FWD*REG_AW-1:0]        fwd_wd,
    input  logic [N_FWD*DATA_W-1:0]        fwd_wdata,
    input  logic [N_FWD-1:0]               fwd_not_ready,
    input  logic                           wb_long_valid,
    input  logic [REG_AW-1:0]              wb_long_addr,
    input  logic [DATA_W-1:0]              wb_long_data,
    output logic [DATA_W-1:0]              reg1_o,
    output logic [DATA_W-1:0]              reg2_o,
    output logic                           stallreq,
    output logic [$clog2(MAX_LONG+1)-1:0]  long_outstanding,
    output logic                           stall_timeout
);

    localparam int NREG = 2 ** REG_AW;
    localparam int CW   = $clog2(MAX_LONG + 1);
    localparam int SW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] MAX_LONG_C = CW'(MAX_LONG);
    localparam logic [SW-1:0] TIMEOUT_C  = SW'(TIMEOUT);

    logic [NREG-1:0]    pending_reg, pending_next;
    logic [CW-1:0]      long_cnt_reg, long_cnt_next;
    logic [SW-1:0]      stall_cnt_reg, stall_cnt_next;
    logic               stall_timeout_reg, stall_timeout_next;

    logic [DATA_W-1:0]  rs_operand, rt_operand;
    logic               rs_load_use, rt_load_use;
    logic               rs_raw, rt_raw;
    logic               waw_hazard, cap_hazard, raw_hazard, load_use;
    logic               clr_eff, set_en, issue, stall_any;

    id_operand_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .N_FWD  (N_FWD)
    ) u_rs_mux (
        .rd_en         (rs_read),
        .addr          (rs_addr),
        .imm           (imm),
        .rf_data       (reg1_data_i),
        .fwd_wreg      (fwd_wreg),
        .fwd_wd        (fwd_wd),
        .fwd_wdata     (fwd_wdata),
        .fwd_not_ready (fwd_not_ready),
        .wb_long_valid (wb_long_valid),
        .wb_long_addr  (wb_long_addr),
        .wb_long_data  (wb_long_data),
        .pending_bit   (pending_reg[rs_addr]),
        .operand       (rs_operand),
        .load_use      (rs_load_use),
        .raw           (rs_raw)
    );

    id_operand_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .N_FWD  (N_FWD)
    ) u_rt_mux (
        .rd_en         (rt_read),
        .addr          (rt_addr),
        .imm           (imm),
        .rf_data       (reg2_data_i),
        .fwd_wreg      (fwd_wreg),
        .fwd_wd        (fwd_wd),
        .fwd_wdata     (fwd_wdata),
        .fwd_not_ready (fwd_not_ready),
        .wb_long_valid (wb_long_valid),
        .wb_long_addr  (wb_long_addr),
        .wb_long_data  (wb_long_data),
        .pending_bit   (pending_reg[rt_addr]),
        .operand       (rt_operand),
        .load_use      (rt_load_use),
        .raw           (rt_raw)
    );

    // A writeback only frees a slot if its register was actually pending;
    // stray writebacks (e.g. issued before a reset) are ignored.
    assign clr_eff    = wb_long_valid && pending_reg[wb_long_addr];

    assign load_use   = rs_load_use || rt_load_use;
    assign raw_hazard = rs_raw || rt_raw;
    assign waw_hazard = issue_wreg && (issue_wd != NOP_REG_ADDR[REG_AW-1:0]) &&
                        pending_reg[issue_wd] &&
                        !(wb_long_valid && (wb_long_addr == issue_wd));
    // Only an effective clear frees a slot, so the count can never overflow.
    assign cap_hazard = issue_long && (long_cnt_reg == MAX_LONG_C) && !clr_eff;

    assign stall_any  = id_valid && !flush &&
                        (load_use || raw_hazard || waw_hazard || cap_hazard);
    assign stallreq   = rst ? stall_any : NO_STOP;
    assign issue      = id_valid && !flush && !stall_any;
    assign set_en     = issue && issue_long && issue_wreg &&
                        (issue_wd != NOP_REG_ADDR[REG_AW-1:0]);

    assign reg1_o = rst ? rs_operand : ZERO_WORD[DATA_W-1:0];
    assign reg2_o = rst ? rt_operand : ZERO_WORD[DATA_W-1:0];

    always_comb begin
        pending_next = pending_reg;
        if (wb_long_valid)
            pending_next[wb_long_addr] = 1'b0;
        // Applied after the clear so a same-address set wins.
        if (set_en)
            pending_next[issue_wd] = 1'b1;
    end

    // Set-wins on one address gives +1 -1 = no change, matching the bit.
    always_comb begin
        long_cnt_next = long_cnt_reg;
        case ({set_en, clr_eff})
            2'b10:   long_cnt_next = long_cnt_reg + 1'b1;
            2'b01:   long_cnt_next = long_cnt_reg - 1'b1;
            default: long_cnt_next = long_cnt_reg;
        endcase
    end

    always_comb begin
        stall_cnt_next = '0;
        if (stall_any == STOP) begin
            if (stall_cnt_reg == TIMEOUT_C)
                stall_cnt_next = stall_cnt_reg;
            else
                stall_cnt_next = stall_cnt_reg + 1'b1;
        end
        stall_timeout_next = stall_timeout_reg || (stall_cnt_next == TIMEOUT_C);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_reg       <= '0;
            long_cnt_reg      <= '0;
            stall_cnt_reg     <= '0;
            stall_timeout_reg <= 1'b0;
        end else begin
            pending_reg       <= pending_next;
            long_cnt_reg      <= long_cnt_next;
            stall_cnt_reg     <= stall_cnt_next;
            stall_timeout_reg <= stall_timeout_next;
        end
    end

    assign long_outstanding = long_cnt_reg;
    assign stall_timeout    = stall_timeout_reg;

endmodule

// File: tb/tb_id_operand_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_id_operand_scoreboard
//   Directed test of id_operand_scoreboard with hand-computed expectations.
//   Inputs change 1 time unit after a rising edge; combinational outputs are
//   checked 1 unit later, registered outputs after the following edge.
// ---------------------------------------------------------------------------
module tb_id_operand_scoreboard;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int N_FWD  = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       id_valid, flush;
    logic                       rs_read, rt_read;
    logic [REG_AW-1:0]          rs_addr, rt_addr;
    logic [DATA_W-1:0]          imm;
    logic                       issue_wreg;
    logic [REG_AW-1:0]          issue_wd;
    logic                       issue_long;
    logic [DATA_W-1:0]          reg1_data_i, reg2_data_i;
    logic [N_FWD-1:0]           fwd_wreg;
    logic [N_FWD*REG_AW-1:0]    fwd_wd;
    logic [N_FWD*DATA_W-1:0]    fwd_wdata;
    logic [N_FWD-1:0]           fwd_not_ready;
    logic                       wb_long_valid;
    logic [REG_AW-1:0]          wb_long_addr;
    logic [DATA_W-1:0]          wb_long_data;
    logic [DATA_W-1:0]          reg1_o, reg2_o;
    logic                       stallreq;
    logic [2:0]                 long_outstanding;
    logic                       stall_timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_operand_scoreboard #(
        .DATA_W   (DATA_W),
        .REG_AW   (REG_AW),
        .N_FWD    (N_FWD),
        .MAX_LONG (4),
        .TIMEOUT  (255)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid         (id_valid),
        .flush            (flush),
        .rs_read          (rs_read),
        .rt_read          (rt_read),
        .rs_addr          (rs_addr),
        .rt_addr          (rt_addr),
        .imm              (imm),
        .issue_wreg       (issue_wreg),
        .issue_wd         (issue_wd),
        .issue_long       (issue_long),
        .reg1_data_i      (reg1_data_i),
        .reg2_data_i      (reg2_data_i),
        .fwd_wreg         (fwd_wreg),
        .fwd_wd           (fwd_wd),
        .fwd_wdata        (fwd_wdata),
        .fwd_not_ready    (fwd_not_ready),
        .wb_long_valid    (wb_long_valid),
        .wb_long_addr     (wb_long_addr),
        .wb_long_data     (wb_long_data),
        .reg1_o           (reg1_o),
        .reg2_o           (reg2_o),
        .stallreq         (stallreq),
        .long_outstanding (long_outstanding),
        .stall_timeout    (stall_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic idle();
        id_valid = 0; flush = 0;
        rs_read = 0; rt_read = 0; rs_addr = '0; rt_addr = '0; imm = '0;
        issue_wreg = 0; issue_wd = '0; issue_long = 0;
        reg1_data_i = '0; reg2_data_i = '0;
        fwd_wreg = '0; fwd_wd = '0; fwd_wdata = '0; fwd_not_ready = '0;
        wb_long_valid = 0; wb_long_addr = '0; wb_long_data = '0;
    endtask

    // Advance one rising edge and leave 1 unit of margin.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_long_op(input logic [REG_AW-1:0] wd);
        idle();
        id_valid = 1; issue_wreg = 1; issue_long = 1; issue_wd = wd;
        #1;
        check($sformatf("issue_r%0d_nostall", wd), stallreq, 0);
        step();
    endtask

    task automatic wb_op(input logic [REG_AW-1:0] a);
        idle();
        wb_long_valid = 1; wb_long_addr = a;
        step();
    endtask

    initial begin
        idle();
        rst = 0;
        imm = 32'h1234;
        step();
        step();
        #1;
        // ---- reset state ----
        check("rst_reg1_forced0", reg1_o, 0);
        check("rst_reg2_forced0", reg2_o, 0);
        check("rst_stallreq", stallreq, 0);
        check("rst_long_outstanding", long_outstanding, 0);
        check("rst_stall_timeout", stall_timeout, 0);
        rst = 1;
        step();

        // ---- forward priority ----
        idle();
        id_valid = 1; rs_read = 1; rs_addr = 5; reg1_data_i = 32'hDEAD;
        fwd_wreg = 2'b11; fwd_wd = {5'd5, 5'd5}; fwd_wdata = {32'h22, 32'h11};
        #1;
        check("fwd0_priority", reg1_o, 32'h11);
        check("fwd0_nostall", stallreq, 0);
        fwd_wreg = 2'b10;
        #1;
        check("fwd1_only", reg1_o, 32'h22);
        fwd_wreg = 2'b00;
        #1;
        check("regfile_fallback", reg1_o, 32'hDEAD);
        wb_long_valid = 1; wb_long_addr = 5; wb_long_data = 32'h77;
        #1;
        check("wb_bypass", reg1_o, 32'h77);
        step();
        check("stray_wb_no_decrement", long_outstanding, 0);
        idle();
        id_valid = 1; rs_read = 0; imm = 32'h55;
        #1;
        check("read_disabled_imm", reg1_o, 32'h55);
        step();

        // ---- load-use ----
        idle();
        id_valid = 1; rt_read = 1; rt_addr = 7;
        fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd7}; fwd_not_ready = 2'b01;
        #1;
        check("load_use_stall", stallreq, 1);
        step();
        fwd_not_ready = 2'b00; fwd_wdata = {32'h0, 32'hABCD};
        #1;
        check("load_ready_nostall", stallreq, 0);
        check("load_ready_reg2", reg2_o, 32'hABCD);
        step();

        // ---- long RAW / bypass ----
        issue_long_op(9);
        check("div_outstanding", long_outstanding, 1);
        idle();
        id_valid = 1; rs_read = 1; rs_addr = 9;
        #1;
        check("raw_pending_stall", stallreq, 1);
        step();
        wb_long_valid = 1; wb_long_addr = 9; wb_long_data = 32'h5;
        #1;
        check("raw_wb_bypass_data", reg1_o, 32'h5);
        check("raw_wb_bypass_nostall", stallreq, 0);
        step();
        check("div_done_outstanding", long_outstanding, 0);

        // ---- capacity and set-wins ----
        for (int r = 1; r <= 4; r++) issue_long_op(REG_AW'(r));
        check("cap_full_count", long_outstanding, 4);
        idle();
        id_valid = 1; issue_wreg = 1; issue_long = 1; issue_wd = 6;
        #1;
        check("cap_fifth_stall", stallreq, 1);
        wb_long_valid = 1; wb_long_addr = 3; issue_wd = 3;
        #1;
        check("setwins_nostall", stallreq, 0);
        step();
        check("setwins_count", long_outstanding, 4);
        idle();
        id_valid = 1; rt_read = 1; rt_addr = 3;
        #1;
        check("setwins_r3_still_pending", stallreq, 1);
        idle();
        id_valid = 1; issue_wreg = 1; issue_wd = 2;
        #1;
        check("waw_stall", stallreq, 1);
        step();
        for (int r = 1; r <= 4; r++) wb_op(REG_AW'(r));
        check("drain_count", long_outstanding, 0);

        // ---- r0 ----
        issue_long_op(0);
        check("r0_never_pending", long_outstanding, 0);
        idle();
        id_valid = 1; rs_read = 1; rs_addr = 0; rt_read = 1; rt_addr = 0;
        reg1_data_i = 32'h33; reg2_data_i = 32'h44;
        fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd0}; fwd_wdata = {32'h0, 32'h99};
        fwd_not_ready = 2'b01;
        #1;
        check("r0_rs_zero", reg1_o, 0);
        check("r0_rt_zero", reg2_o, 0);
        check("r0_nostall", stallreq, 0);
        step();

        // ---- flush ----
        issue_long_op(10);
        check("flush_setup_count", long_outstanding, 1);
        idle();
        id_valid = 1; flush = 1; rs_read = 1; rs_addr = 10;
        issue_wreg = 1; issue_long = 1; issue_wd = 11;
        #1;
        check("flush_nostall", stallreq, 0);
        step();
        check("flush_no_issue", long_outstanding, 1);
        flush = 0; issue_wreg = 0; issue_long = 0;
        #1;
        check("flush_pending_kept", stallreq, 1);

        // ---- watchdog ----
        repeat (254) step();
        check("wdog_254_clear", stall_timeout, 0);
        step();
        check("wdog_255_set", stall_timeout, 1);
        id_valid = 0;
        step();
        step();
        check("wdog_sticky", stall_timeout, 1);

        // ---- reset mid-operation ----
        id_valid = 1;
        rst = 0;
        #1;
        check("rst_mid_stall_forced0", stallreq, 0);
        check("rst_mid_reg1_forced0", reg1_o, 0);
        step();
        rst = 1;
        #1;
        check("rst_mid_count", long_outstanding, 0);
        check("rst_mid_timeout", stall_timeout, 0);
        check("rst_mid_pending_gone", stallreq, 0);
        idle();
        wb_long_valid = 1; wb_long_addr = 10;
        step();
        check("rst_stale_wb_ignored", long_outstanding, 0);
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
